// File: rtl/led_driver_rx.sv
// -----------------------------------------------------------------------------
// led_driver_rx
// Receive side of a serial-loaded LED driver. The controller clocks a
// grayscale or dot-correction frame into a shift register over led_sclk,
// latches it with led_xlat, and the block then produces one PWM output per
// channel, timed against the led_gsclk reference.
//
// All controller signals are asynchronous to clock and are brought in through
// two-flop synchronisers. Rising edges are found by comparing synchroniser
// stage 2 against a stage-3 copy, so an input change captured at clock edge k
// is acted on at edge k+2.
//
// Ports
//   clock       system clock, all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   led_sclk    serial shift clock (asynchronous)
//   led_sin     serial data, taken on a led_sclk rise
//   led_mode    0 = grayscale frame, 1 = dot-correction frame (used at xlat)
//   led_blank   forces all PWM outputs off and clears the PWM counter
//   led_xlat    rising edge latches the shift register
//   led_gsclk   PWM reference clock, each rise advances the PWM counter
//   led_sout    shift-register MSB, for daisy-chaining
//   led_xerr    active-low frame-length error, held between latches
//   pwm_out     per-channel PWM drive (registered)
//   dc_value    latched dot-correction data
//   cycle_done  one-clock pulse when the PWM counter reaches its final value
// -----------------------------------------------------------------------------
module led_driver_rx #(
    parameter int CHANNELS = 16,
    parameter int GS_BITS  = 12,
    parameter int DC_BITS  = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         led_sclk,
    input  logic                         led_sin,
    input  logic                         led_mode,
    input  logic                         led_blank,
    input  logic                         led_xlat,
    input  logic                         led_gsclk,
    output logic                         led_sout,
    output logic                         led_xerr,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic [CHANNELS*DC_BITS-1:0]  dc_value,
    output logic                         cycle_done
);

    localparam int SR_W   = CHANNELS * GS_BITS;
    localparam int DC_W   = CHANNELS * DC_BITS;
    localparam int GS_LEN = SR_W;
    localparam int DC_LEN = DC_W;

    localparam logic [GS_BITS-1:0] CNT_MAX = {GS_BITS{1'b1}};
    localparam logic [GS_BITS-1:0] CNT_PEN = {{(GS_BITS-1){1'b1}}, 1'b0};

    // Bit positions inside the synchroniser vectors
    localparam int I_SCLK  = 5;
    localparam int I_SIN   = 4;
    localparam int I_MODE  = 3;
    localparam int I_BLANK = 2;
    localparam int I_XLAT  = 1;
    localparam int I_GSCLK = 0;

    logic [5:0]          sync_p0;
    logic [5:0]          sync_p1;
    logic [5:0]          sync_p2;
    logic [2:0]          edge_p3;   // {sclk, xlat, gsclk} stage-3 copies

    logic                sclk_rise;
    logic                xlat_rise;
    logic                gsclk_rise;
    logic                sin_s;
    logic                mode_s;
    logic                blank_s;

    logic [SR_W-1:0]     shift_reg;
    logic [7:0]          bit_cnt;
    logic [SR_W-1:0]     gs_latch;
    logic [GS_BITS-1:0]  pwm_cnt;

    // Saturating increment for the shift bit counter (holds at 255)
    function automatic logic [7:0] bit_cnt_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Saturating increment for the PWM counter (holds at all ones)
    function automatic logic [GS_BITS-1:0] pwm_cnt_inc(input logic [GS_BITS-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    assign sync_p0 = {led_sclk, led_sin, led_mode, led_blank, led_xlat, led_gsclk};

    // ---- stage p1/p2/p3: synchronisers and edge-detect copies ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
            edge_p3 <= '0;
        end else begin
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            edge_p3 <= {sync_p2[I_SCLK], sync_p2[I_XLAT], sync_p2[I_GSCLK]};
        end
    end

    always_comb begin
        sclk_rise  = sync_p2[I_SCLK]  & ~edge_p3[2];
        xlat_rise  = sync_p2[I_XLAT]  & ~edge_p3[1];
        gsclk_rise = sync_p2[I_GSCLK] & ~edge_p3[0];
        sin_s      = sync_p2[I_SIN];
        mode_s     = sync_p2[I_MODE];
        blank_s    = sync_p2[I_BLANK];
    end

    // ---- frame capture: shift register, bit count, latches ----
    // A latch in the same clock as a shift sees the pre-shift register and
    // count; the incoming bit then becomes the first bit of the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            gs_latch  <= '0;
            dc_value  <= '0;
            led_xerr  <= 1'b1;
        end else begin
            if (xlat_rise) begin
                if (!mode_s) begin
                    gs_latch <= shift_reg;
                    led_xerr <= (32'(bit_cnt) == GS_LEN);
                end else begin
                    dc_value <= shift_reg[DC_W-1:0];
                    led_xerr <= (32'(bit_cnt) == DC_LEN);
                end
            end

            if (sclk_rise) begin
                shift_reg <= {shift_reg[SR_W-2:0], sin_s};
            end

            if (xlat_rise) begin
                bit_cnt <= sclk_rise ? 8'd1 : 8'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt_inc(bit_cnt);
            end
        end
    end

    assign led_sout = shift_reg[SR_W-1];

    // ---- PWM: counter, registered outputs, end-of-cycle pulse ----
    // pwm_out compares against the current counter, so a new GS latch shows
    // up one clock later and the counter itself keeps running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt    <= '0;
            pwm_out    <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (blank_s) begin
                pwm_cnt <= '0;
                pwm_out <= '0;
            end else begin
                if (gsclk_rise) begin
                    pwm_cnt    <= pwm_cnt_inc(pwm_cnt);
                    cycle_done <= (pwm_cnt == CNT_PEN);
                end
                for (int n = 0; n < CHANNELS; n++) begin
                    pwm_out[n] <= (pwm_cnt < gs_latch[n*GS_BITS +: GS_BITS]);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_driver_rx.sv
`timescale 1ns/1ps
module tb_led_driver_rx;

    localparam int CH  = 16;
    localparam int GB  = 12;
    localparam int DB  = 6;
    localparam int SRW = CH * GB;
    localparam int DCW = CH * DB;
    localparam int KMAX = (1 << GB) - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            led_sclk = 1'b0;
    logic            led_sin = 1'b0;
    logic            led_mode = 1'b0;
    logic            led_blank = 1'b0;
    logic            led_xlat = 1'b0;
    logic            led_gsclk = 1'b0;
    logic            led_sout;
    logic            led_xerr;
    logic [CH-1:0]   pwm_out;
    logic [DCW-1:0]  dc_value;
    logic            cycle_done;

    led_driver_rx #(.CHANNELS(CH), .GS_BITS(GB), .DC_BITS(DB)) dut (
        .clock      (clock),
        .reset      (reset),
        .led_sclk   (led_sclk),
        .led_sin    (led_sin),
        .led_mode   (led_mode),
        .led_blank  (led_blank),
        .led_xlat   (led_xlat),
        .led_gsclk  (led_gsclk),
        .led_sout   (led_sout),
        .led_xerr   (led_xerr),
        .pwm_out    (pwm_out),
        .dc_value   (dc_value),
        .cycle_done (cycle_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Reference model state: bits as seen by the receiver
    logic [SRW-1:0] model_sr;
    logic [SRW-1:0] gs_m;
    logic [DCW-1:0] dc_m;
    logic           xerr_m;
    int             cnt_m;
    int             k_m;      // gsclks counted since the last clear
    logic           blank_m;

    function automatic logic [CH-1:0] exp_pwm();
        logic [CH-1:0] r;
        r = '0;
        for (int n = 0; n < CH; n++)
            r[n] = !blank_m && (k_m < int'(gs_m[n*GB +: GB]));
        return r;
    endfunction

    task automatic model_reset();
        model_sr = '0; gs_m = '0; dc_m = '0; xerr_m = 1'b1;
        cnt_m = 0; k_m = 0;
    endtask

    task automatic model_latch(input logic m);
        if (!m) begin
            gs_m = model_sr;
            xerr_m = (cnt_m == SRW);
        end else begin
            dc_m = model_sr[DCW-1:0];
            xerr_m = (cnt_m == DCW);
        end
        cnt_m = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic shift_bit(input logic b);
        led_sin = b; led_sclk = 1'b1;
        wait_clk(3);
        led_sclk = 1'b0;
        wait_clk(3);
        model_sr = {model_sr[SRW-2:0], b};
        if (cnt_m < 255) cnt_m++;
    endtask

    task automatic shift_frame(input logic [SRW-1:0] f, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(f[i]);
    endtask

    task automatic xlat_pulse(input logic m);
        led_mode = m; led_xlat = 1'b1;
        wait_clk(3);
        led_xlat = 1'b0;
        wait_clk(3);
        model_latch(m);
    endtask

    task automatic gsclk_pulse();
        led_gsclk = 1'b1;
        for (int i = 0; i < 3; i++) begin wait_clk(1); if (cycle_done) done_seen++; end
        led_gsclk = 1'b0;
        for (int i = 0; i < 3; i++) begin wait_clk(1); if (cycle_done) done_seen++; end
        if (!blank_m && k_m < KMAX) k_m++;
    endtask

    task automatic set_blank(input logic v);
        led_blank = v;
        wait_clk(4);
        blank_m = v;
        if (v) k_m = 0;
    endtask

    function automatic logic [SRW-1:0] rand_frame(input int maxv);
        logic [SRW-1:0] f;
        for (int n = 0; n < CH; n++) f[n*GB +: GB] = GB'($urandom_range(0, maxv));
        return f;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset(); blank_m = 1'b0;
        wait_clk(3);
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL reset_xerr got %b want 1", led_xerr); end
        checks++; if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm got %h want 0", pwm_out); end
        checks++; if (dc_value !== '0) begin errors++; $display("FAIL reset_dc got %h want 0", dc_value); end
        checks++; if (cycle_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cycle_done); end
        checks++; if (led_sout !== 1'b0) begin errors++; $display("FAIL reset_sout got %b want 0", led_sout); end
        reset = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_single_channel();
        logic [SRW-1:0] f;
        int high;
        f = '0; f[GB-1:0] = 12'd3;
        shift_frame(f, SRW);
        checks++; if (led_sout !== model_sr[SRW-1]) begin errors++; $display("FAIL single_sout got %b want %b", led_sout, model_sr[SRW-1]); end
        xlat_pulse(1'b0);
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL single_xerr got %b want 1", led_xerr); end
        high = 0;
        for (int g = 0; g <= 5; g++) begin
            if (g > 0) gsclk_pulse();
            checks++;
            if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL single_pwm step %0d got %h want %h", g, pwm_out, exp_pwm()); end
            if (pwm_out[0]) high++;
        end
        checks++; if (high !== 3) begin errors++; $display("FAIL single_high_periods got %0d want 3", high); end
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL single_xerr_hold got %b want 1", led_xerr); end
    endtask

    task automatic test_frame_length();
        set_blank(1'b1); set_blank(1'b0);
        shift_frame(rand_frame(20), SRW - 1);
        led_mode = 1'b0; led_xlat = 1'b1;
        wait_clk(1);
        checks++; if (led_xerr !== xerr_m) begin errors++; $display("FAIL len_xerr_early got %b want %b", led_xerr, xerr_m); end
        wait_clk(2);
        checks++; if (led_xerr !== 1'b0) begin errors++; $display("FAIL len_xerr_short got %b want 0", led_xerr); end
        led_xlat = 1'b0;
        wait_clk(3);
        model_latch(1'b0);
        checks++; if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL len_pwm_short got %h want %h", pwm_out, exp_pwm()); end
        shift_frame(rand_frame(20), SRW);
        xlat_pulse(1'b0);
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL len_xerr_full got %b want 1", led_xerr); end
        checks++; if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL len_pwm_full got %h want %h", pwm_out, exp_pwm()); end
    endtask

    task automatic test_dot_correction();
        logic [SRW-1:0] f;
        logic [CH-1:0] pwm_before;
        pwm_before = pwm_out;
        f = '1;
        shift_frame(f, DCW);
        xlat_pulse(1'b1);
        checks++; if (dc_value !== {DCW{1'b1}}) begin errors++; $display("FAIL dc_ones got %h want all ones", dc_value); end
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL dc_xerr got %b want 1", led_xerr); end
        checks++; if (pwm_out !== pwm_before || pwm_out !== exp_pwm()) begin errors++; $display("FAIL dc_gs_unchanged got %h want %h", pwm_out, exp_pwm()); end
        f = rand_frame(KMAX);
        shift_frame(f, DCW);
        xlat_pulse(1'b1);
        checks++; if (dc_value !== dc_m) begin errors++; $display("FAIL dc_random got %h want %h", dc_value, dc_m); end
    endtask

    task automatic test_random_frames();
        logic [SRW-1:0] f;
        for (int it = 0; it < 3; it++) begin
            set_blank(1'b1); set_blank(1'b0);
            f = rand_frame((it == 2) ? KMAX : 15);
            for (int i = SRW - 1; i >= 0; i--) begin
                shift_bit(f[i]);
                if (i % 37 == 0) begin
                    checks++; if (led_sout !== model_sr[SRW-1]) begin errors++; $display("FAIL rand_sout bit %0d got %b want %b", i, led_sout, model_sr[SRW-1]); end
                end
            end
            xlat_pulse(1'b0);
            checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL rand_xerr iter %0d got %b want 1", it, led_xerr); end
            for (int g = 0; g < 18; g++) begin
                checks++;
                if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL rand_pwm iter %0d step %0d got %h want %h", it, g, pwm_out, exp_pwm()); end
                gsclk_pulse();
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [SRW-1:0] f;
        logic b;
        set_blank(1'b1); set_blank(1'b0);
        f = rand_frame(15);
        shift_frame(f, SRW);
        b = 1'($urandom_range(0, 1)) | 1'b1;
        led_sin = b; led_sclk = 1'b1; led_mode = 1'b0; led_xlat = 1'b1;
        wait_clk(3);
        led_sclk = 1'b0; led_xlat = 1'b0;
        wait_clk(3);
        model_latch(1'b0);
        model_sr = {model_sr[SRW-2:0], b};
        cnt_m = 1;
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL simul_xerr got %b want 1", led_xerr); end
        checks++; if (led_sout !== model_sr[SRW-1]) begin errors++; $display("FAIL simul_sout got %b want %b", led_sout, model_sr[SRW-1]); end
        for (int g = 0; g < 16; g++) begin
            checks++;
            if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL simul_pwm step %0d got %h want %h", g, pwm_out, exp_pwm()); end
            gsclk_pulse();
        end
        shift_frame(rand_frame(KMAX), SRW - 1);
        xlat_pulse(1'b0);
        checks++; if (led_xerr !== xerr_m || xerr_m !== 1'b1) begin errors++; $display("FAIL simul_count got %b want 1", led_xerr); end
    endtask

    task automatic test_saturation();
        int d0;
        shift_frame('1, SRW);
        xlat_pulse(1'b0);
        set_blank(1'b1); set_blank(1'b0);
        d0 = done_seen;
        for (int g = 0; g < 4100; g++) begin
            gsclk_pulse();
            checks++;
            if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL sat_pwm gsclk %0d got %h want %h", g + 1, pwm_out, exp_pwm()); end
        end
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL sat_cycle_done pulses got %0d want 1", done_seen - d0); end
        checks++; if (pwm_out !== '0) begin errors++; $display("FAIL sat_pwm_off got %h want 0", pwm_out); end
        set_blank(1'b1);
        checks++; if (pwm_out !== '0) begin errors++; $display("FAIL sat_blank got %h want 0", pwm_out); end
        set_blank(1'b0);
        checks++; if (pwm_out !== exp_pwm() || exp_pwm() !== {CH{1'b1}}) begin errors++; $display("FAIL sat_counter_cleared got %h want ffff", pwm_out); end
    endtask

    task automatic test_reset_midframe();
        logic [SRW-1:0] f;
        shift_frame(rand_frame(KMAX), 100);
        reset = 1'b1;
        wait_clk(2);
        model_reset();
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL rst_mid_xerr got %b want 1", led_xerr); end
        checks++; if (pwm_out !== '0) begin errors++; $display("FAIL rst_mid_pwm got %h want 0", pwm_out); end
        checks++; if (dc_value !== '0) begin errors++; $display("FAIL rst_mid_dc got %h want 0", dc_value); end
        checks++; if (led_sout !== 1'b0 || cycle_done !== 1'b0) begin errors++; $display("FAIL rst_mid_sout_done got %b%b want 00", led_sout, cycle_done); end
        reset = 1'b0;
        wait_clk(3);
        f = rand_frame(15);
        shift_frame(f, SRW);
        xlat_pulse(1'b0);
        checks++; if (led_xerr !== 1'b1) begin errors++; $display("FAIL rst_mid_frame_xerr got %b want 1", led_xerr); end
        for (int g = 0; g < 16; g++) begin
            checks++;
            if (pwm_out !== exp_pwm()) begin errors++; $display("FAIL rst_mid_pwm step %0d got %h want %h", g, pwm_out, exp_pwm()); end
            gsclk_pulse();
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_frame_length();
        test_dot_correction();
        test_random_frames();
        test_simultaneous();
        test_saturation();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_driver_rx.md
LED_DRIVER_RX -- requirements
Module: led_driver_rx

Interface
REQ-001 Parameter CHANNELS, default 16: number of PWM output channels.
REQ-002 Parameter GS_BITS, default 12: grayscale bits per channel.
REQ-003 Parameter DC_BITS, default 6: dot-correction bits per channel.
REQ-004 clock  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 led_sclk  input  1  serial shift clock from the controller, asynchronous to clock.
REQ-007 led_sin  input  1  serial data, valid at led_sclk rising edge.
REQ-008 led_mode  input  1  0 = grayscale frame, 1 = dot-correction frame; sampled at the led_xlat edge.
REQ-009 led_blank  input  1  high forces all outputs off and clears the PWM counter.
REQ-010 led_xlat  input  1  rising edge latches the shift register.
REQ-011 led_gsclk  input  1  PWM reference clock; each rising edge advances the counter.
REQ-012 led_sout  output  1  MSB of the shift register (daisy-chain output).
REQ-013 led_xerr  output  1  active-low frame-length error flag.
REQ-014 pwm_out  output  CHANNELS  per-channel PWM drive, registered.
REQ-015 dc_value  output  CHANNELS*DC_BITS  latched dot-correction data.
REQ-016 cycle_done  output  1  one-clock pulse at the end of a grayscale cycle.

Function
REQ-017 Synchronisation: led_sclk, led_sin, led_mode, led_blank, led_xlat and led_gsclk each pass through a 2-flop synchroniser; rising edges are detected from stage 2 against a stage-3 copy.
REQ-018 Edge timing: a level change captured at clock edge k is acted on at edge k+2.
REQ-019 Shift: on each detected led_sclk rise, the CHANNELS*GS_BITS-bit shift register shifts left and takes synchronised led_sin into bit 0.
REQ-020 Shift count: the bit counter increments on each shift and saturates at 255.
REQ-021 Channel order: the first bit shifted is the MSB of channel CHANNELS-1. Channel n grayscale data is gs[n*GS_BITS +: GS_BITS].
REQ-022 GS latch: on an led_xlat rise with mode=0, the full shift register is copied to the GS latch.
REQ-023 DC latch: on an led_xlat rise with mode=1, the low CHANNELS*DC_BITS shift-register bits are copied to dc_value.
REQ-024 Frame-length check: at each latch, led_xerr is driven 0 if the shift count is not equal to CHANNELS*GS_BITS (mode=0) or CHANNELS*DC_BITS (mode=1), and 1 otherwise. The value is held until the next latch.
REQ-025 After a latch, the bit counter clears to 0.
REQ-026 Simultaneous xlat and sclk edges in one clock: the latch and length check use the pre-shift register and count; the shift still occurs; the bit counter becomes 1.
REQ-027 Blank: while synchronised blank is 1, the PWM counter is 0 and pwm_out is all 0 on the next clock.
REQ-028 PWM counter: GS_BITS wide; increments on each detected gsclk rise while blank is 0.
REQ-029 PWM counter saturation: the counter saturates at 2^GS_BITS-1 and does not wrap.
REQ-030 PWM output: pwm_out[n] is registered as (blank==0) AND (counter < gs[n]). A gs value of 0 means never on; 4095 means on for 4095 gsclks.
REQ-031 cycle_done pulses for one clock when the counter transitions from 2^GS_BITS-2 to 2^GS_BITS-1.
REQ-032 A GS latch mid-cycle takes effect on pwm_out on the next clock without resetting the counter.
REQ-033 led_sout is always equal to the current shift-register MSB.

Reset
REQ-034 Reset values: while reset=1, all synchroniser stages, the shift register, bit counter, GS latch, dc_value, PWM counter, pwm_out and cycle_done are 0, and led_xerr is 1.
REQ-035 Reset asserted mid-frame discards partial shift data. After release, the first detected edges are treated as new (stage-3 copies are 0).

Verification
REQ-036 Scenario: shift 192 bits with channel 0 = 12'd3 and all others 0, xlat with mode=0, blank low, 5 gsclks -> pwm_out[0] is high for exactly 3 gsclk periods, other channels stay 0, led_xerr stays 1.
REQ-037 Scenario: shift 191 bits then xlat -> led_xerr goes 0 two to three clocks after the xlat rise; a following 192-bit frame plus xlat -> led_xerr returns to 1.
REQ-038 Scenario: mode=1, shift 96 bits of 6'h3F then xlat -> dc_value is all ones, GS latch unchanged, led_xerr is 1.
REQ-039 Scenario: all channels = 12'hFFF, 4100 gsclks -> counter holds at 4095, cycle_done pulses exactly once, pwm_out all 0 after the 4095th gsclk; raising blank -> counter returns to 0.
REQ-040 Scenario: xlat and sclk rising in the same clock -> the latched frame excludes the new bit and the bit counter reads 1.
REQ-041 Scenario: assert reset after 100 shifted bits -> all outputs return to reset values; a subsequent 192-bit frame latches correctly.
